// File: rtl/bmu_multicycle_if.sv
// Start/busy/done handshake bundle between the execute stage and the
// iterative bit-manipulation unit.
interface bmu_multicycle_if;
  logic        start;
  logic [4:0]  option;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        busy;
  logic        done;
  logic [31:0] result;

  // Pipeline side: issues requests and consumes results.
  modport master (
    output start, option, in_x, in_y,
    input  busy, done, result
  );

  // Unit side: accepts requests and reports completion.
  modport slave (
    input  start, option, in_x, in_y,
    output busy, done, result
  );
endinterface

// File: rtl/bmu_multicycle.sv
// Iterative companion to the combinational BMU. Executes CLMUL, CLMULH,
// CLMULR, CLZ, CPOP and CTZ in a fixed number of RUN cycles
// (32 / BITS_PER_CYCLE). The latency does not depend on the operand
// values, so the pipeline stall length is always known in advance.
module bmu_multicycle #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bmu_multicycle_if.slave bus
);

  localparam int         STEPS     = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  localparam logic [4:0] OP_CLMUL  = 5'b00001;
  localparam logic [4:0] OP_CLMULH = 5'b00010;
  localparam logic [4:0] OP_CLMULR = 5'b00011;
  localparam logic [4:0] OP_CLZ    = 5'b00100;
  localparam logic [4:0] OP_CPOP   = 5'b00101;
  localparam logic [4:0] OP_CTZ    = 5'b00110;

  // Only power-of-two chunk sizes that divide 32 evenly are meaningful.
  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bad_bits_per_cycle
      $error("bmu_multicycle: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit reversal lets CLZ reuse the CTZ scan (count from bit 0 upward).
  function automatic logic [31:0] f_reverse(input logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

  // Final result selection from the accumulator or the counter.
  function automatic logic [31:0] f_result(input logic [4:0]  op,
                                           input logic [63:0] acc,
                                           input logic [5:0]  cnt);
    logic [31:0] r;
    case (op)
      OP_CLMUL:                r = acc[31:0];
      OP_CLMULH:               r = acc[63:32];
      OP_CLMULR:               r = acc[62:31];
      OP_CLZ, OP_CPOP, OP_CTZ: r = {26'd0, cnt};
      default:                 r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_op;
  logic [63:0] r_xs;     // in_x, shifted left one chunk per step
  logic [31:0] r_scan;   // bits still to scan: in_y, in_x or reversed in_x
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_found;
  logic [5:0]  r_step;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_opt_valid;
  logic        w_accept;
  logic        w_finish;
  logic        w_is_clmul;
  logic [63:0] w_acc_nx;
  logic [5:0]  w_cnt_nx;
  logic        w_found_nx;
  logic [31:0] w_load_scan;

  assign w_opt_valid = (bus.option >= OP_CLMUL) && (bus.option <= OP_CTZ);
  assign w_is_clmul  = (r_op == OP_CLMUL) || (r_op == OP_CLMULH) || (r_op == OP_CLMULR);

  // Choose which operand feeds the scan register when a request is accepted.
  always_comb begin
    w_load_scan = bus.in_x;
    case (bus.option)
      OP_CLMUL, OP_CLMULH, OP_CLMULR: w_load_scan = bus.in_y;
      OP_CLZ:                         w_load_scan = f_reverse(bus.in_x);
      default:                        w_load_scan = bus.in_x;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and control strobes; DONE accepts start just like IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = w_opt_valid ? S_RUN : S_DONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_step == LAST_STEP) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = w_opt_valid ? S_RUN : S_DONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // One step of work: process the low BITS_PER_CYCLE bits of the scan register.
  always_comb begin
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_found_nx = r_found;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (w_is_clmul) begin
        if (r_scan[j]) begin
          w_acc_nx = w_acc_nx ^ (r_xs << j);
        end else begin
          w_acc_nx = w_acc_nx;
        end
      end else if (r_op == OP_CPOP) begin
        w_cnt_nx = w_cnt_nx + {5'd0, r_scan[j]};
      end else begin
        // CLZ/CTZ: count zeros until the first one, then freeze the count.
        if (!w_found_nx) begin
          if (r_scan[j]) begin
            w_found_nx = 1'b1;
          end else begin
            w_cnt_nx = w_cnt_nx + 6'd1;
          end
        end else begin
          w_cnt_nx = w_cnt_nx;
        end
      end
    end
  end

  // Datapath registers: load on accept, advance one chunk per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 5'd0;
      r_xs     <= 64'd0;
      r_scan   <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_found  <= 1'b0;
      r_step   <= 6'd0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_acc   <= 64'd0;
      r_cnt   <= 6'd0;
      r_found <= 1'b0;
      r_step  <= 6'd0;
      if (w_opt_valid) begin
        r_op   <= bus.option;
        r_xs   <= {32'd0, bus.in_x};
        r_scan <= w_load_scan;
      end else begin
        // Invalid request completes immediately with a zero result.
        r_op     <= 5'd0;
        r_xs     <= 64'd0;
        r_scan   <= 32'd0;
        r_result <= 32'd0;
      end
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_found <= w_found_nx;
      r_xs    <= r_xs << BITS_PER_CYCLE;
      r_scan  <= r_scan >> BITS_PER_CYCLE;
      r_step  <= r_step + 6'd1;
      if (w_finish) begin
        r_result <= f_result(r_op, w_acc_nx, w_cnt_nx);
      end else begin
        r_result <= r_result;
      end
    end else begin
      r_step <= r_step;
    end
  end

  // Registered handshake outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_RUN);
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: doc/bmu_multicycle.md
Name: bmu_multicycle

Overview:
Iterative companion unit to the combinational bit-manipulation unit. It executes the Zbb/Zbc operations that the combinational path defers: CLMUL, CLMULH, CLMULR, CLZ, CPOP and CTZ.
- Sits beside the BMU in the execute stage and receives the same 5-bit option code and operands.
- Uses a start/busy/done handshake so the pipeline can stall on it.
- Latency is fixed and data-independent, which gives deterministic stall timing.

Parameters:
BITS_PER_CYCLE, 1, operand bits processed per RUN cycle. Legal values are 1, 2, 4, 8, 16, 32; any other value must fail elaboration.
STEPS, 32/BITS_PER_CYCLE, derived localparam (not overridable): number of RUN cycles.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
option  input  5  op code: 00001 CLMUL, 00010 CLMULH, 00011 CLMULR, 00100 CLZ, 00101 CPOP, 00110 CTZ; all other codes invalid
in_x  input  32  rs1 operand
in_y  input  32  rs2 operand (used by CLMUL* only)
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse: result valid
result  output  32  result; holds until the next accepted start or reset

Behaviour:
- Reset (async assert, sync-safe deassert) forces: state IDLE, busy=0, done=0, result=0, all internal registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 with a valid option: at that edge (E0), latch option, in_x and in_y; clear the accumulator/count; step counter=0; go to RUN; busy=1.
- IDLE, start=1 with an invalid option: go to DONE with result=0; done pulses the next cycle; busy never asserts.
- RUN: each edge processes the next BITS_PER_CYCLE bits and increments the step counter. At edge E(STEPS), register result, go to DONE, busy=0.
- DONE: done=1 for exactly one cycle. start is accepted here exactly as in IDLE (back-to-back ops, no bubble); otherwise return to IDLE.
- Latency: done is high in the cycle after edge E(STEPS). For BITS_PER_CYCLE=1 that is 32 cycles after the accepting edge; for BITS_PER_CYCLE=8 it is 4 cycles.
- start while busy=1 is ignored. Latched operands and option are not disturbed.
- Input changes after E0 have no effect.
- CLMUL family: 64-bit accumulator acc. For each bit i=0..31 (ascending, chunked), if in_y[i]=1 then acc ^= zero-extended in_x << i.
  - CLMUL = acc[31:0]
  - CLMULH = acc[63:32]
  - CLMULR = acc[62:31]
- CPOP: count of 1 bits in in_x, range 0..32, zero-extended to 32 bits.
- CLZ: number of 0 bits scanned from bit 31 downward before the first 1. in_x=0 gives 32.
- CTZ: number of 0 bits scanned from bit 0 upward before the first 1. in_x=0 gives 32.
- CLZ/CTZ always run all STEPS cycles; there is no early termination. Implement with a "found" flag that freezes the count.
- Reset mid-operation: the operation is abandoned immediately, outputs go to their reset values, and no done pulse is produced.
- result is undefined-free: it is never X after reset and changes only at the DONE transition.

Test Plan:
- BITS_PER_CYCLE=1, CLMUL in_x=0x00000003, in_y=0x00000003 -> busy high for 32 cycles, done pulses once 32 cycles after start edge, result=0x00000005.
- CLMULH in_x=0x80000000, in_y=0x00000002 -> result=0x00000001. Same operands with CLMULR -> result=0x00000002. Same operands with CLMUL -> 0x00000000.
- CLZ in_x=0x00010000 -> 15. CTZ in_x=0x00000000 -> 32. CPOP in_x=0xF0F0F0F0 -> 16. CLZ in_x=0xFFFFFFFF -> 0. Repeat all with BITS_PER_CYCLE=8 -> same results, done 4 cycles after start.
- start re-asserted with different operands during RUN -> ignored, original result delivered. start asserted in DONE cycle -> new op accepted with no idle cycle, second done exactly STEPS+1 cycles after the first.
- option=00000 (invalid) -> busy stays 0, done pulses next cycle, result=0.
- rst_n pulled low at step 10 of a CPOP -> busy/done/result=0 immediately, no done pulse. A fresh CPOP after release -> correct result.
